shift_left_seq: RTL and testbench



---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_left_stage.sv | 22 ++
 rtl/shift_left_seq.sv | 149 ++++++++++++++
 tb/tb_shift_left_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the sequential left shifter (shift_left_seq).
// Stage weights are listed highest first, matching the order in which stages execute.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned SHAMT_W_DEF = $clog2(WIDTH_DEF);

  localparam int unsigned STAGE_WEIGHT [SHAMT_W_DEF] = '{32'd16, 32'd8, 32'd4, 32'd2, 32'd1};

endpackage

// File: rtl/shift_left_stage.sv
// One binary-weighted left-shift stage: shifts by 2**k when enabled, zero-filling from the LSB.
module shift_left_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   acc_in,
  input  logic [SHAMT_W-1:0] k,
  input  logic               en,
  output logic [WIDTH-1:0]   acc_out
);

  // Selected stage shift or pass-through
  always_comb begin
    acc_out = acc_in;
    if (en) begin
      acc_out = acc_in << (32'd1 << k);
    end else begin
      acc_out = acc_in;
    end
  end

endmodule

// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter, one binary-weighted stage per clock.
// Build option SHIFT_SKIP_ZERO_EN: visit only the set bits of the shift amount.
module shift_left_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       ready,
  output logic                       done,
  output logic [WIDTH-1:0]           result_out
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [SHAMT_W-1:0]   rem_q, rem_d;
  logic [SHAMT_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  logic [SHAMT_W-1:0]   stage_k_s;
  logic                 stage_en_s;
  logic [WIDTH-1:0]     stage_acc_s;

  shift_left_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .acc_in  (acc_q),
    .k       (stage_k_s),
    .en      (stage_en_s),
    .acc_out (stage_acc_s)
  );

`ifdef SHIFT_SKIP_ZERO_EN
  logic [SHAMT_W-1:0] msb_s;

  // Highest set bit of rem; later iterations override lower ones
  always_comb begin
    msb_s = '0;
    for (int i = 0; i < int'(SHAMT_W); i++) begin
      if (rem_q[i]) begin
        msb_s = SHAMT_W'(i);
      end else begin
        msb_s = msb_s;
      end
    end
  end
`endif

  // Next-state, datapath and output decode
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    k_d        = k_q;
    result_d   = result_q;
    stage_k_s  = k_q;
    stage_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = data_in;
          rem_d = shamt;
          k_d   = SHAMT_W'(SHAMT_W - 1);
`ifdef SHIFT_SKIP_ZERO_EN
          // Zero shift finishes on the accepting edge itself
          if (shamt == '0) begin
            state_d  = DONE;
            result_d = data_in;
          end else begin
            state_d  = SHIFT;
          end
`else
          state_d = SHIFT;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
`ifdef SHIFT_SKIP_ZERO_EN
        stage_k_s  = msb_s;
        stage_en_s = 1'b1;
        acc_d      = stage_acc_s;
        rem_d      = rem_q & ~(SHAMT_W'(1) << msb_s);
        if (rem_d == '0) begin
          state_d  = DONE;
          result_d = stage_acc_s;
        end else begin
          state_d  = SHIFT;
        end
`else
        stage_k_s  = k_q;
        stage_en_s = rem_q[k_q];
        acc_d      = stage_acc_s;
        k_d        = k_q - SHAMT_W'(1);
        if (k_q == '0) begin
          state_d  = DONE;
          result_d = stage_acc_s;
        end else begin
          state_d  = SHIFT;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      k_q      <= SHAMT_W'(SHAMT_W - 1);
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      k_q      <= k_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign result_out = result_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: latency/result model plus directed and random traffic.
// Honours SHIFT_SKIP_ZERO_EN to pick the expected latency.
module tb_shift_left_seq;

`ifdef SHIFT_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic [4:0]  shamt   = 5'd0;
  logic        ready;
  logic        done;
  logic [31:0] result_out;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  shift_left_seq dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .data_in    (data_in),
    .shamt      (shamt),
    .ready      (ready),
    .done       (done),
    .result_out (result_out)
  );

  function automatic logic [31:0] model_shift(input logic [31:0] d, input logic [4:0] s);
    logic [63:0] wide;
    wide = {32'd0, d} << s;
    return wide[31:0];
  endfunction

  function automatic int model_lat(input logic [4:0] s);
    if (SKIP) return $countones(s);
    else return 5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 busy counting edges, 2 done
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_pend  = 32'd0;
  logic [31:0] m_result = 32'd0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase  <= 0;
      m_left   <= 0;
      m_pend   <= 32'd0;
      m_result <= 32'd0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_pend <= model_shift(data_in, shamt);
          if (model_lat(shamt) == 0) begin
            m_phase  <= 2;
            m_result <= model_shift(data_in, shamt);
          end else begin
            m_phase <= 1;
            m_left  <= model_lat(shamt);
          end
        end
        1: begin
          if (m_left == 1) begin
            m_phase  <= 2;
            m_result <= m_pend;
          end
          m_left <= m_left - 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      check("cyc_ready", {31'd0, ready}, {31'd0, m_phase == 0});
      check("cyc_done", {31'd0, done}, {31'd0, m_phase == 2});
      check("cyc_result", result_out, m_result);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clock);
    while (ready !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
    end
    check("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [31:0] exp_res,
                        input int exp_lat, input string nm);
    int n;
    wait_ready();
    start   = 1'b1;
    data_in = d;
    shamt   = s;
    @(posedge clock); #1;
    start   = 1'b0;
    data_in = $urandom;
    shamt   = 5'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check({nm, "_result"}, result_out, exp_res);
    check({nm, "_latency"}, n, exp_lat);
  endtask

  initial begin
    int          n;
    int          pulses;
    int          acc_n;
    bit          got1;
    bit          prev;
    logic [31:0] r;

    #12;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result_out, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    check("model_pin_a", model_shift(32'hDEAD_BEEF, 5'd16), 32'hBEEF_0000);
    check("model_pin_b", model_shift(32'h1234_5678, 5'd8), 32'h3456_7800);
    check("model_pin_c", model_shift(32'h0000_0001, 5'd31), 32'h8000_0000);

    run_op(32'h0000_0001, 5'd31, 32'h8000_0000, 5, "msb");
    @(posedge clock); #1;
    check("msb_ready_back", {31'd0, ready}, 32'd1);
    check("msb_done_low", {31'd0, done}, 32'd0);

    run_op(32'hDEAD_BEEF, 5'd16, 32'hBEEF_0000, SKIP ? 1 : 5, "s16");
    run_op(32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, SKIP ? 0 : 5, "s0");

    // Start pulsed mid-shift must be ignored
    wait_ready();
    start = 1'b1; data_in = 32'h0000_0003; shamt = 5'd30;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    start = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd1;
    @(posedge clock); #1; start = 1'b0;
    pulses = 0; r = 32'd0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin
        pulses++;
        r = result_out;
      end
    end
    check("ign_pulses", pulses, 32'd1);
    check("ign_result", r, 32'hC000_0000);

    // Reset during the third shift cycle
    wait_ready();
    start = 1'b1; data_in = 32'h0000_00FF; shamt = 5'd31;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result_out, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) pulses++;
    end
    check("mid_rst_no_done", pulses, 32'd0);

    // Back-to-back with start held high
    wait_ready();
    start = 1'b1; data_in = 32'h0000_00FF; shamt = 5'd4;
    @(posedge clock); #1;
    data_in = 32'h1234_5678; shamt = 5'd8;
    prev = ready; got1 = 1'b0; acc_n = -1; r = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1 && !got1) begin
        r = result_out;
        got1 = 1'b1;
      end
      if (prev && ready === 1'b0) begin
        acc_n = i;
        break;
      end
      prev = ready;
    end
    start = 1'b0;
    check("b2b_first", r, 32'h0000_0FF0);
    check("b2b_interval", acc_n, SKIP ? 3 : 7);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("b2b_second", result_out, 32'h3456_7800);

    // Random traffic, checked every cycle by the model comparison
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      start   = ($urandom_range(0, 2) == 0);
      data_in = $urandom;
      case ($urandom_range(0, 5))
        0:       shamt = 5'd0;
        1:       shamt = 5'd31;
        default: shamt = 5'($urandom);
      endcase
    end
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
